// File: rtl/drr_input_arbiter.sv
// drr_input_arbiter: merges NUM_QUEUES packet streams onto one datapath
// using packet round robin (MODE=0) or byte-fair deficit round robin.
module drr_input_arbiter #(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter int NUM_QUEUES      = 8,
   parameter int FIFO_DEPTH_BITS = 2,
   parameter int MODE            = 1,
   parameter int QUANTUM         = 1518,
   parameter int DEFICIT_WIDTH   = 16,
   parameter logic [CTRL_WIDTH-1:0] HDR_CTRL = 'hFF,
   localparam int QW = $clog2(NUM_QUEUES)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
   input  logic [NUM_QUEUES-1:0]            in_wr,
   output logic [NUM_QUEUES-1:0]            in_rdy,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [CTRL_WIDTH-1:0]            out_ctrl,
   output logic                             out_wr,
   input  logic                             out_rdy,
   output logic [QW-1:0]                    cur_queue,
   output logic [NUM_QUEUES-1:0]            pkt_sent
);

   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam int SW    = DEFICIT_WIDTH + 33;
   localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = (FIFO_DEPTH_BITS+1)'(DEPTH);
   localparam logic [FIFO_DEPTH_BITS:0] NF_CNT   = (FIFO_DEPTH_BITS+1)'(DEPTH - 1);
   localparam logic [SW-1:0] DEF_MAX = SW'({DEFICIT_WIDTH{1'b1}});

   typedef enum logic {SELECT, WR_PKT} state_t;

   state_t state, state_n;

   logic [DATA_WIDTH-1:0]    head_data_a [NUM_QUEUES];
   logic [CTRL_WIDTH-1:0]    head_ctrl_a [NUM_QUEUES];
   logic [DEFICIT_WIDTH-1:0] deficit [NUM_QUEUES];
   logic [NUM_QUEUES-1:0]    empty, pop_vec, credited;
   logic [DATA_WIDTH-1:0]    head_data;
   logic [CTRL_WIDTH-1:0]    head_ctrl;
   logic [15:0]              len;
   logic [SW-1:0]            cur_def, credit_sum;
   logic [DEFICIT_WIDTH-1:0] credit_sat, debit_val;
   logic pop, adv, credit, debit, clear, uncredit;
   logic after_zero, last_word, fits;

   for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_fifo
      logic [DATA_WIDTH-1:0]      dmem [DEPTH];
      logic [CTRL_WIDTH-1:0]      cmem [DEPTH];
      logic [FIFO_DEPTH_BITS-1:0] wp, rp;
      logic [FIFO_DEPTH_BITS:0]   cnt;
      logic                       push;

      assign push = in_wr[g] && (cnt != FULL_CNT);

      always_ff @(posedge clk) begin
         if (push) begin
            dmem[wp] <= in_data[g*DATA_WIDTH +: DATA_WIDTH];
            cmem[wp] <= in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH];
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
         end else begin
            if (push) wp <= wp + 1'b1;
            if (pop_vec[g]) rp <= rp + 1'b1;
            if (push && !pop_vec[g]) cnt <= cnt + 1'b1;
            else if (!push && pop_vec[g]) cnt <= cnt - 1'b1;
         end
      end

      assign head_data_a[g] = dmem[rp];
      assign head_ctrl_a[g] = cmem[rp];
      assign empty[g]       = (cnt == '0);
      assign in_rdy[g]      = (cnt < NF_CNT);
   end

   assign head_data = head_data_a[cur_queue];
   assign head_ctrl = head_ctrl_a[cur_queue];
   assign len       = (head_ctrl == HDR_CTRL) ? head_data[15:0] : '0;
   assign cur_def   = SW'(deficit[cur_queue]);
   assign fits      = SW'(len) <= cur_def;
   assign credit_sum = cur_def + SW'(QUANTUM);
   assign credit_sat = (credit_sum > DEF_MAX) ? '1
                     : credit_sum[DEFICIT_WIDTH-1:0];
   assign debit_val = deficit[cur_queue] - DEFICIT_WIDTH'(len);
   // A packet ends on the first nonzero ctrl after a ctrl==0 word.
   assign last_word = after_zero && (head_ctrl != '0);
   assign pop_vec   = pop ? (NUM_QUEUES'(1) << cur_queue) : '0;

   always_comb begin
      state_n  = state;
      pop      = 1'b0;
      adv      = 1'b0;
      credit   = 1'b0;
      debit    = 1'b0;
      clear    = 1'b0;
      uncredit = 1'b0;
      unique case (state)
         SELECT: begin
            if (out_rdy) begin
               if (empty[cur_queue]) begin
                  clear = 1'b1;
                  adv   = 1'b1;
               end else if (MODE == 0) begin
                  state_n = WR_PKT;
               end else if (!credited[cur_queue]) begin
                  credit = 1'b1;
               end else if (fits) begin
                  debit   = 1'b1;
                  state_n = WR_PKT;
               end else begin
                  uncredit = 1'b1;
                  adv      = 1'b1;
               end
            end
         end
         WR_PKT: begin
            if (out_rdy && !empty[cur_queue]) begin
               pop = 1'b1;
               if (last_word) begin
                  state_n = SELECT;
                  adv     = (MODE == 0);
               end
            end
         end
         default: state_n = SELECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SELECT;
         cur_queue  <= '0;
         after_zero <= 1'b0;
         credited   <= '0;
         for (int i = 0; i < NUM_QUEUES; i++) deficit[i] <= '0;
      end else begin
         state <= state_n;
         if (adv)
            cur_queue <= (cur_queue == QW'(NUM_QUEUES - 1)) ? '0
                       : cur_queue + 1'b1;
         if (state == SELECT) after_zero <= 1'b0;
         else if (pop) after_zero <= (head_ctrl == '0);
         if (clear) begin
            deficit[cur_queue]  <= '0;
            credited[cur_queue] <= 1'b0;
         end
         if (credit) begin
            deficit[cur_queue]  <= credit_sat;
            credited[cur_queue] <= 1'b1;
         end
         if (debit) deficit[cur_queue] <= debit_val;
         if (uncredit) credited[cur_queue] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_wr   <= 1'b0;
         out_data <= '0;
         out_ctrl <= '0;
         pkt_sent <= '0;
      end else begin
         out_wr   <= pop;
         pkt_sent <= (pop && last_word) ? pop_vec : '0;
         if (pop) begin
            out_data <= head_data;
            out_ctrl <= head_ctrl;
         end
      end
   end

endmodule

// File: tb/tb_drr_input_arbiter.sv
// Directed bench for drr_input_arbiter: DRR instance (8 queues) and
// a packet round-robin instance (2 queues).
module tb_drr_input_arbiter;

   typedef struct packed {
      logic [7:0]  c;
      logic [63:0] d;
   } word_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [511:0] in_data = '0;
   logic [63:0]  in_ctrl = '0;
   logic [7:0]   in_wr = '0;
   logic [7:0]   in_rdy;
   logic [63:0]  out_data;
   logic [7:0]   out_ctrl;
   logic         out_wr;
   logic         out_rdy = 1'b0;
   logic [2:0]   cur_queue;
   logic [7:0]   pkt_sent;

   logic [127:0] r_in_data = '0;
   logic [15:0]  r_in_ctrl = '0;
   logic [1:0]   r_in_wr = '0;
   logic [1:0]   r_in_rdy;
   logic [63:0]  r_out_data;
   logic [7:0]   r_out_ctrl;
   logic         r_out_wr;
   logic         r_out_rdy = 1'b0;
   logic [0:0]   r_cur_queue;
   logic [1:0]   r_pkt_sent;

   word_t src [8][$];
   word_t rsrc [2][$];
   word_t exp_q [$];
   word_t fw;
   bit    feed_en = 1'b1;
   int    n_cmp = 0;
   int    n_bad = 0;

   drr_input_arbiter dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .in_wr(in_wr), .in_rdy(in_rdy),
      .out_data(out_data), .out_ctrl(out_ctrl),
      .out_wr(out_wr), .out_rdy(out_rdy),
      .cur_queue(cur_queue), .pkt_sent(pkt_sent)
   );

   drr_input_arbiter #(.NUM_QUEUES(2), .MODE(0)) dut_rr (
      .clk(clk), .reset(reset),
      .in_data(r_in_data), .in_ctrl(r_in_ctrl),
      .in_wr(r_in_wr), .in_rdy(r_in_rdy),
      .out_data(r_out_data), .out_ctrl(r_out_ctrl),
      .out_wr(r_out_wr), .out_rdy(r_out_rdy),
      .cur_queue(r_cur_queue), .pkt_sent(r_pkt_sent)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   // Sources push one word per cycle whenever the channel is ready.
   initial forever begin
      @(negedge clk);
      if (feed_en) begin
         for (int i = 0; i < 8; i++) begin
            if (!reset && in_rdy[i] && src[i].size() > 0) begin
               fw = src[i].pop_front();
               in_wr[i] = 1'b1;
               in_data[i*64 +: 64] = fw.d;
               in_ctrl[i*8 +: 8] = fw.c;
            end else begin
               in_wr[i] = 1'b0;
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (!reset && r_in_rdy[i] && rsrc[i].size() > 0) begin
               fw = rsrc[i].pop_front();
               r_in_wr[i] = 1'b1;
               r_in_data[i*64 +: 64] = fw.d;
               r_in_ctrl[i*8 +: 8] = fw.c;
            end else begin
               r_in_wr[i] = 1'b0;
            end
         end
      end
   end

   task automatic add_pkt(input bit rr, input int q, input int len,
                          input int tag, input bit keep);
      word_t w;
      int n;
      n = (len + 7) / 8;
      for (int j = -1; j < n; j++) begin
         if (j < 0) begin
            w.c = 8'hFF;
            w.d = {32'(tag), 16'h0, 16'(len)};
         end else begin
            w.c = (j == n - 1) ? 8'h80 : 8'h00;
            w.d = {32'(tag), 32'(j)};
         end
         if (rr) rsrc[q].push_back(w);
         else src[q].push_back(w);
         if (keep) exp_q.push_back(w);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) src[i].delete();
      for (int i = 0; i < 2; i++) rsrc[i].delete();
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      out_rdy = 1'b0;
      do_reset();
      n_cmp += 7;
      if (out_wr !== 1'b0) begin
         n_bad++; $display("FAIL rst_out_wr: got %0h want 0", out_wr);
      end
      if (out_ctrl !== 8'h0) begin
         n_bad++; $display("FAIL rst_out_ctrl: got %0h want 0", out_ctrl);
      end
      if (out_data !== 64'h0) begin
         n_bad++; $display("FAIL rst_out_data: got %0h want 0", out_data);
      end
      if (cur_queue !== 3'd0) begin
         n_bad++; $display("FAIL rst_cur_queue: got %0d want 0", cur_queue);
      end
      if (pkt_sent !== 8'h0) begin
         n_bad++; $display("FAIL rst_pkt_sent: got %0h want 0", pkt_sent);
      end
      if (in_rdy !== 8'hFF) begin
         n_bad++; $display("FAIL rst_in_rdy: got %0h want ff", in_rdy);
      end
      if (dut.deficit[5] !== 16'd0) begin
         n_bad++; $display("FAIL rst_deficit: got %0d want 0", dut.deficit[5]);
      end
   endtask

   task automatic test_fifo_fill();
      logic [3:0] rdy_exp;
      word_t w;
      int got;
      rdy_exp = 4'b0011;
      out_rdy = 1'b0;
      do_reset();
      feed_en = 1'b0;
      in_wr = '0;
      add_pkt(0, 0, 24, 32'hA0, 1);
      src[0].delete();
      for (int k = 0; k < 4; k++) begin
         w = exp_q[k];
         in_wr[0] = 1'b1;
         in_data[63:0] = w.d;
         in_ctrl[7:0] = w.c;
         @(negedge clk);
         n_cmp++;
         if (in_rdy[0] !== rdy_exp[k]) begin
            n_bad++;
            $display("FAIL fill_in_rdy_%0d: got %0b want %0b",
                     k + 1, in_rdy[0], rdy_exp[k]);
         end
      end
      in_wr[0] = 1'b0;
      feed_en = 1'b1;
      out_rdy = 1'b1;
      got = 0;
      for (int c = 0; c < 60 && got < 4; c++) begin
         @(negedge clk);
         if (out_wr) begin
            n_cmp++;
            if ({out_ctrl, out_data} !== exp_q[got]) begin
               n_bad++;
               $display("FAIL fill_word_%0d: got %h want %h",
                        got, {out_ctrl, out_data}, exp_q[got]);
            end
            if (got == 3) begin
               n_cmp++;
               if (pkt_sent !== 8'h01) begin
                  n_bad++;
                  $display("FAIL fill_pkt_sent: got %h want 01", pkt_sent);
               end
            end
            got++;
         end
      end
      n_cmp++;
      if (got != 4) begin
         n_bad++; $display("FAIL fill_count: got %0d want 4", got);
      end
   endtask

   task automatic test_backpressure();
      int got;
      int sent;
      out_rdy = 1'b1;
      do_reset();
      add_pkt(0, 2, 64, 32'hB2, 1);
      got = 0;
      sent = 0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         if (out_wr) begin
            n_cmp++;
            if (out_rdy !== 1'b1) begin
               n_bad++;
               $display("FAIL bp_wr_after_rdy0: got out_wr=1 want 0");
            end
            if (got < exp_q.size()) begin
               n_cmp++;
               if ({out_ctrl, out_data} !== exp_q[got]) begin
                  n_bad++;
                  $display("FAIL bp_word_%0d: got %h want %h",
                           got, {out_ctrl, out_data}, exp_q[got]);
               end
            end
            got++;
         end
         if (pkt_sent[2]) sent++;
         out_rdy = ~out_rdy;
      end
      n_cmp += 2;
      if (got != 9) begin
         n_bad++; $display("FAIL bp_count: got %0d want 9", got);
      end
      if (sent != 1) begin
         n_bad++; $display("FAIL bp_pkt_sent: got %0d want 1", sent);
      end
      out_rdy = 1'b1;
   endtask

   task automatic test_drr_fairness();
      int b0, b1, last_len, diff;
      bit done;
      out_rdy = 1'b1;
      do_reset();
      for (int p = 0; p < 500; p++) add_pkt(0, 0, 64, p, 0);
      for (int p = 0; p < 25; p++) add_pkt(0, 1, 1500, p, 0);
      b0 = 0;
      b1 = 0;
      last_len = 0;
      done = 1'b0;
      for (int c = 0; c < 20000 && !done; c++) begin
         @(negedge clk);
         if (out_wr && out_ctrl == 8'hFF) last_len = int'(out_data[15:0]);
         if (pkt_sent[0]) b0 += last_len;
         if (pkt_sent[1]) begin
            b1 += last_len;
            if (b0 + b1 >= 30000) done = 1'b1;
         end
      end
      diff = (b0 > b1) ? b0 - b1 : b1 - b0;
      n_cmp += 2;
      if (!done) begin
         n_bad++;
         $display("FAIL drr_progress: got %0d bytes want >=30000", b0 + b1);
      end
      if (diff > 1518) begin
         n_bad++;
         $display("FAIL drr_fairness: got q0=%0d q1=%0d want diff<=1518",
                  b0, b1);
      end
   endtask

   task automatic test_rr_mode();
      int k;
      logic [1:0] want;
      r_out_rdy = 1'b1;
      do_reset();
      for (int p = 0; p < 10; p++) add_pkt(1, 0, 64, p, 0);
      for (int p = 0; p < 4; p++) add_pkt(1, 1, 1500, p, 0);
      k = 0;
      for (int c = 0; c < 5000 && k < 6; c++) begin
         @(negedge clk);
         if (r_pkt_sent != 2'b00) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (r_pkt_sent !== want) begin
               n_bad++;
               $display("FAIL rr_order_%0d: got %b want %b",
                        k, r_pkt_sent, want);
            end
            k++;
         end
      end
      n_cmp++;
      if (k != 6) begin
         n_bad++; $display("FAIL rr_count: got %0d want 6", k);
      end
      r_out_rdy = 1'b0;
   endtask

   task automatic test_big_packet();
      int got;
      bit left, done;
      out_rdy = 1'b1;
      do_reset();
      add_pkt(0, 3, 3000, 32'hC3, 0);
      got = 0;
      left = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge clk);
         if (out_wr) got++;
         if (!left && cur_queue == 3'd4) begin
            left = 1'b1;
            n_cmp += 2;
            if (got != 0) begin
               n_bad++;
               $display("FAIL big_first_visit: got %0d words want 0", got);
            end
            if (dut.deficit[3] !== 16'd1518) begin
               n_bad++;
               $display("FAIL big_deficit1: got %0d want 1518",
                        dut.deficit[3]);
            end
         end
         if (pkt_sent[3]) begin
            done = 1'b1;
            n_cmp += 2;
            if (got != 376) begin
               n_bad++; $display("FAIL big_words: got %0d want 376", got);
            end
            if (dut.deficit[3] !== 16'd36) begin
               n_bad++;
               $display("FAIL big_deficit2: got %0d want 36",
                        dut.deficit[3]);
            end
            @(negedge clk);
            n_cmp++;
            if (dut.deficit[3] !== 16'd0) begin
               n_bad++;
               $display("FAIL big_deficit_clr: got %0d want 0",
                        dut.deficit[3]);
            end
         end
      end
      n_cmp++;
      if (!done) begin
         n_bad++; $display("FAIL big_sent: got none want pkt_sent[3]");
      end
   endtask

   task automatic test_reset_midpkt();
      int got;
      bit bad_def;
      out_rdy = 1'b1;
      do_reset();
      add_pkt(0, 0, 160, 32'hD0, 0);
      got = 0;
      for (int c = 0; c < 100 && got < 4; c++) begin
         @(negedge clk);
         if (out_wr) got++;
      end
      reset = 1'b1;
      for (int i = 0; i < 8; i++) src[i].delete();
      @(negedge clk);
      bad_def = 1'b0;
      for (int i = 0; i < 8; i++)
         if (dut.deficit[i] !== 16'd0) bad_def = 1'b1;
      n_cmp += 4;
      if (got != 4) begin
         n_bad++; $display("FAIL mid_pre_words: got %0d want 4", got);
      end
      if (out_wr !== 1'b0) begin
         n_bad++; $display("FAIL mid_out_wr: got %0b want 0", out_wr);
      end
      if (cur_queue !== 3'd0) begin
         n_bad++; $display("FAIL mid_cur_queue: got %0d want 0", cur_queue);
      end
      if (bad_def) begin
         n_bad++; $display("FAIL mid_deficit: got nonzero want all 0");
      end
      reset = 1'b0;
      exp_q.delete();
      add_pkt(0, 5, 64, 32'hE5, 1);
      got = 0;
      for (int c = 0; c < 80 && got < 9; c++) begin
         @(negedge clk);
         if (out_wr) begin
            n_cmp++;
            if ({out_ctrl, out_data} !== exp_q[got]) begin
               n_bad++;
               $display("FAIL mid_word_%0d: got %h want %h",
                        got, {out_ctrl, out_data}, exp_q[got]);
            end
            if (got == 8) begin
               n_cmp++;
               if (pkt_sent !== 8'h20) begin
                  n_bad++;
                  $display("FAIL mid_pkt_sent: got %h want 20", pkt_sent);
               end
            end
            got++;
         end
      end
      n_cmp++;
      if (got != 9) begin
         n_bad++; $display("FAIL mid_post_count: got %0d want 9", got);
      end
   endtask

   initial begin
      test_reset();
      test_fifo_fill();
      test_backpressure();
      test_big_packet();
      test_drr_fairness();
      test_rr_mode();
      test_reset_midpkt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
